fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: CLK  input  1  rising-edge clock, sole clock domain.
REQ-003 Port: RST_N  input  1  asynchronous, active-low reset.
REQ-004 Port: pc_write  input  1  PC may advance (from hazard unit).
REQ-005 Port: decodeIR_en  input  1  decode register may load (from hazard unit).
REQ-006 Port: flush  input  1  taken branch/jump redirect from execute.
REQ-007 Port: target  input  32  redirect address, valid with flush.
REQ-008 Port: imem_req  output  1  instruction fetch request.
REQ-009 Port: imem_addr  output  32  fetch address, equals PC.
REQ-010 Port: imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-011 Port: imem_rdata  input  32  fetched instruction.
REQ-012 Port: decodeIR_out  output  32  decode-stage instruction register.
REQ-013 Port: decode_pc  output  32  PC of decodeIR_out.
REQ-014 Port: decode_valid  output  1  decodeIR_out holds a real instruction.

Function
REQ-015 FSM states SHALL be REQ, HOLD, DROP.
REQ-016 REQ: imem_req=1, imem_addr=PC; held stable until imem_ack; ack allowed in the first cycle of req.
REQ-017 REQ, ack, decodeIR_en=1: decodeIR_out<=imem_rdata, decode_pc<=PC, decode_valid<=1; PC<=PC+4 if pc_write; stay REQ.
REQ-018 REQ, ack, decodeIR_en=0: capture imem_rdata in hold register; go HOLD; imem_req=0 in HOLD.
REQ-019 HOLD, decodeIR_en=1: load hold register into decode register, valid=1; PC<=PC+4 if pc_write; go REQ.
REQ-020 flush SHALL take priority over ack, stall and HOLD: PC<=target; decodeIR_out<=32'h00000013, decode_valid<=0; hold register discarded.
REQ-021 flush in REQ without ack in the same cycle: go DROP; imem_req stays 1 with the old address until ack; returned data discarded; then REQ at target.
REQ-022 flush in REQ with ack, or flush in HOLD: go REQ at target next cycle.
REQ-023 flush in DROP: update PC to new target; remain DROP.
REQ-024 PC+4 SHALL wrap modulo 2^32; target bits [1:0] used as given.
REQ-025 decode register SHALL hold contents while decodeIR_en=0 and no flush.

Reset
REQ-026 RST_N low SHALL asynchronously force: PC=RESET_VECTOR, state=REQ, imem_req=0, decodeIR_out=32'h00000013, decode_pc=0, decode_valid=0, hold register=0.
REQ-027 First imem_req SHALL assert the first cycle after RST_N deasserts; any response in flight at reset is ignored.

Configuration
REQ-028 Macro FETCH_BUBBLE_EN defined: REQ without ack while decodeIR_en=1 loads 32'h00000013 into decode register, decode_valid=0.
REQ-029 Macro FETCH_BUBBLE_EN absent: decode register keeps previous contents, decode_valid<=0.

Structure
REQ-030 Shared package SHALL hold the NOP constant 32'h00000013, the FSM state enum and the instruction-width localparam.
REQ-031 One sub-module fetch_pc_reg (PC register with load/increment/redirect) SHALL be instantiated; FSM and decode register live in fetch_stage.

Verification
REQ-032 Reset release, ack every cycle, all enables 1 -> imem_addr 0,4,8; decode_pc 0,4,8 one cycle later; decode_valid=1.
REQ-033 Ack with decodeIR_en=0 for 3 cycles, rdata=32'h00A00093 -> HOLD, imem_req=0, decodeIR_out unchanged; re-enable -> decodeIR_out=32'h00A00093, PC+4.
REQ-034 flush target=32'h100 while request pending, ack 2 cycles later with 32'hDEADBEEF -> data discarded, decodeIR_out=NOP, next imem_addr=32'h100.
REQ-035 flush and ack same cycle, target=32'h40 -> decode gets NOP, valid=0, next imem_addr=32'h40.
REQ-036 PC=32'hFFFFFFFC accepted -> next imem_addr=32'h0; RST_N low mid-HOLD -> outputs at reset values immediately, no clock edge needed.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage.
//   INSTR_W      : instruction / address width
//   NOP_INSTR    : canonical no-op (addi x0,x0,0) used for bubbles and flushes
//   fetch_state_e: fetch FSM states (REQ, HOLD, DROP)
package fetch_stage_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   CLK, RST_N   : clock, asynchronous active-low reset
//   redirect     : load redirectAddr (has priority over advance)
//   redirectAddr : redirect target, used exactly as given (bits [1:0] included)
//   advance      : step the PC by 4 (wraps modulo 2^32)
//   pc           : current PC
module fetch_pc_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirectAddr,
  input  logic               advance,
  output logic [INSTR_W-1:0] pc
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc <= RESET_VECTOR;
    end else if (redirect) begin
      pc <= redirectAddr;
    end else if (advance) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues fetches to instruction memory, buffers a
// returned instruction while decode is stalled, and handles redirects.
// Ports:
//   CLK, RST_N    : clock, asynchronous active-low reset
//   pc_write      : PC may advance when an instruction is handed to decode
//   decodeIR_en   : decode register may load
//   flush, target : redirect request and its address
//   imem_req/addr : fetch request and address
//   imem_ack/rdata: fetch completion and returned instruction
//   decodeIR_out, decode_pc, decode_valid : decode-stage instruction register
//   fsmState      : current FSM state (debug visibility)
// Build option: define FETCH_BUBBLE_EN to write a NOP into the decode
// register on cycles where decode is enabled but no instruction arrives;
// otherwise the old contents stay and only decode_valid drops.
//
// Memory handshake: imem_req is held high with a stable imem_addr until a
// cycle where imem_ack is high; that cycle completes the fetch and imem_rdata
// is sampled in it. imem_ack while imem_req is low is ignored. Ack may come
// in the very first cycle imem_req is high.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               pc_write,
  input  logic               decodeIR_en,
  input  logic               flush,
  input  logic [INSTR_W-1:0] target,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] decodeIR_out,
  output logic [INSTR_W-1:0] decode_pc,
  output logic               decode_valid,
  output logic [1:0]         fsmState
);

  fetch_state_e       state;
  logic               imemReqQ;
  logic [INSTR_W-1:0] holdReg;
  logic [INSTR_W-1:0] dropAddr;
  logic [INSTR_W-1:0] pc;
  logic               ackValid;
  logic               pcAdvance;

  // Acks only count against an outstanding request (stale responses from
  // before reset are ignored because imemReqQ resets low).
  assign ackValid = imem_ack && imemReqQ;

  // PC steps only when an instruction actually enters decode.
  assign pcAdvance = pc_write && !flush && decodeIR_en &&
                     ((state == REQ && ackValid) || state == HOLD);

  fetch_pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .redirect    (flush),
    .redirectAddr(target),
    .advance     (pcAdvance),
    .pc          (pc)
  );

  // While dropping, the already-issued request must stay on the bus unchanged
  // even though the PC has moved to the redirect target.
  assign imem_addr = (state == DROP) ? dropAddr : pc;
  assign imem_req  = imemReqQ;
  assign fsmState  = state;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= REQ;
      imemReqQ     <= 1'b0;
      decodeIR_out <= NOP_INSTR;
      decode_pc    <= '0;
      decode_valid <= 1'b0;
      holdReg      <= '0;
      dropAddr     <= '0;
    end else begin
      unique case (state)
        REQ: begin
          if (flush) begin
            decodeIR_out <= NOP_INSTR;
            decode_valid <= 1'b0;
            holdReg      <= '0;
            imemReqQ     <= 1'b1;
            // A request still in flight must be completed and its data thrown away.
            if (imemReqQ && !imem_ack) begin
              state    <= DROP;
              dropAddr <= pc;
            end
          end else if (ackValid) begin
            if (decodeIR_en) begin
              decodeIR_out <= imem_rdata;
              decode_pc    <= pc;
              decode_valid <= 1'b1;
              imemReqQ     <= 1'b1;
            end else begin
              holdReg  <= imem_rdata;
              state    <= HOLD;
              imemReqQ <= 1'b0;
            end
          end else begin
            imemReqQ <= 1'b1;
            if (decodeIR_en) begin
`ifdef FETCH_BUBBLE_EN
              decodeIR_out <= NOP_INSTR;
`endif
              decode_valid <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (flush) begin
            decodeIR_out <= NOP_INSTR;
            decode_valid <= 1'b0;
            holdReg      <= '0;
            state        <= REQ;
            imemReqQ     <= 1'b1;
          end else if (decodeIR_en) begin
            decodeIR_out <= holdReg;
            decode_pc    <= pc;
            decode_valid <= 1'b1;
            state        <= REQ;
            imemReqQ     <= 1'b1;
          end
        end
        DROP: begin
          if (flush) begin
            decodeIR_out <= NOP_INSTR;
            decode_valid <= 1'b0;
            holdReg      <= '0;
          end
          // The stale response ends the drop even if a new flush arrives in the
          // same cycle; the PC already holds the newest target.
          if (ackValid) begin
            state <= REQ;
          end
        end
        default: begin
          state    <= REQ;
          imemReqQ <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// traffic, with a cycle-level reference model feeding an expected queue and a
// separate monitor comparing DUT outputs after every clock edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        pc_write = 1'b0;
  logic        decodeIR_en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] decodeIR_out;
  logic [31:0] decode_pc;
  logic        decode_valid;
  logic [1:0]  fsmState;

  int testsRun = 0;
  int testsFailed = 0;

  // {imem_req, decode_valid, imem_addr, decode_pc, decodeIR_out}
  logic [97:0] exp_q[$];

  // Reference model: PC, a one-entry buffer for an instruction that decode
  // could not take yet, and a "discard next response" marker for redirects
  // that overtake an in-flight fetch.
  logic [31:0] mPc;
  logic        mReq;
  logic        mDrop;
  logic [31:0] mDropAddr;
  logic        mBufV;
  logic [31:0] mBufData;
  logic [31:0] mIr;
  logic [31:0] mDpc;
  logic        mDv;

  fetch_stage dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .pc_write    (pc_write),
    .decodeIR_en (decodeIR_en),
    .flush       (flush),
    .target      (target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .decodeIR_out(decodeIR_out),
    .decode_pc   (decode_pc),
    .decode_valid(decode_valid),
    .fsmState    (fsmState)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- helpers ----------------
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] modelAddr();
    return mDrop ? mDropAddr : mPc;
  endfunction

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic modelReset();
    mPc = 32'h0; mReq = 1'b0; mDrop = 1'b0; mDropAddr = '0;
    mBufV = 1'b0; mBufData = '0; mIr = NOP; mDpc = '0; mDv = 1'b0;
    exp_q.delete();
  endtask

  task automatic deliver(input logic [31:0] instr, input logic pcw);
    mIr = instr; mDpc = mPc; mDv = 1'b1;
    if (pcw) mPc = mPc + 32'd4;
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic modelStep(input logic en, input logic pcw, input logic fl,
                           input logic [31:0] tg, input logic ak, input logic [31:0] rd);
    logic acked;
    acked = ak && mReq;
    if (fl) begin
      mIr = NOP; mDv = 1'b0; mBufV = 1'b0;
      if (mReq && !acked) begin
        if (!mDrop) mDropAddr = mPc;
        mDrop = 1'b1;
      end else begin
        mDrop = 1'b0;
      end
      mPc = tg;
      mReq = 1'b1;
    end else if (mDrop) begin
      if (acked) mDrop = 1'b0;
    end else if (mBufV) begin
      if (en) begin
        deliver(mBufData, pcw);
        mBufV = 1'b0;
        mReq = 1'b1;
      end
    end else if (acked) begin
      if (en) begin
        deliver(rd, pcw);
      end else begin
        mBufV = 1'b1; mBufData = rd; mReq = 1'b0;
      end
    end else begin
      mReq = 1'b1;
      if (en) begin
`ifdef FETCH_BUBBLE_EN
        mIr = NOP;
`endif
        mDv = 1'b0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic driveStep(input logic en, input logic pcw, input logic fl,
                           input logic [31:0] tg, input logic ak, input logic [31:0] rd);
    decodeIR_en = en; pc_write = pcw; flush = fl; target = tg;
    imem_ack = ak; imem_rdata = rd;
    modelStep(en, pcw, fl, tg, ak, rd);
    exp_q.push_back({mReq, mDv, modelAddr(), mDpc, mIr});
  endtask

  task automatic doCycle(input logic en, input logic pcw, input logic fl,
                         input logic [31:0] tg, input logic ak, input logic [31:0] rd);
    @(negedge CLK);
    driveStep(en, pcw, fl, tg, ak, rd);
  endtask

  task automatic doFetch(input logic en, input logic pcw);
    doCycle(en, pcw, 1'b0, 32'h0, 1'b1, memWord(modelAddr()));
  endtask

  task automatic afterEdge();
    @(posedge CLK);
    #2;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge CLK) begin
    logic [97:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("imem_req", {31'b0, imem_req}, {31'b0, e[97]});
      chk("decode_valid", {31'b0, decode_valid}, {31'b0, e[96]});
      chk("imem_addr", imem_addr, e[95:64]);
      chk("decode_pc", decode_pc, e[63:32]);
      chk("decodeIR_out", decodeIR_out, e[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    modelReset();
    #1;
    RST_N = 1'b0;
    imem_ack = 1'b1;              // stale response while in reset
    imem_rdata = 32'hBAD0_BAD0;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_decodeIR", decodeIR_out, NOP);
    chk("rst_decode_pc", decode_pc, 32'h0);
    chk("rst_decode_valid", {31'b0, decode_valid}, 32'd0);

    // Sequential fetch with ack every cycle.
    @(negedge CLK);
    RST_N = 1'b1;
    driveStep(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0);
    afterEdge();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    doFetch(1'b1, 1'b1);
    afterEdge();
    chk("seq_pc0", decode_pc, 32'h0);
    chk("seq_addr4", imem_addr, 32'h4);
    doFetch(1'b1, 1'b1);
    afterEdge();
    chk("seq_pc4", decode_pc, 32'h4);
    chk("seq_addr8", imem_addr, 32'h8);
    doFetch(1'b1, 1'b1);
    afterEdge();
    chk("seq_pc8", decode_pc, 32'h8);
    chk("seq_valid", {31'b0, decode_valid}, 32'd1);

    // Decode stalled while a fetch completes.
    doCycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00A0_0093);
    doCycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
    doCycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
    afterEdge();
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_ir_kept", decodeIR_out, memWord(32'h8));
    doCycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    afterEdge();
    chk("hold_release_ir", decodeIR_out, 32'h00A0_0093);
    chk("hold_release_pc", decode_pc, 32'hC);
    chk("hold_release_addr", imem_addr, 32'h10);

    // Redirect while a request is pending; stale data is discarded.
    doCycle(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    afterEdge();
    chk("drop_old_addr", imem_addr, 32'h10);
    chk("drop_req", {31'b0, imem_req}, 32'd1);
    doCycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    doCycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    afterEdge();
    chk("drop_ir_nop", decodeIR_out, NOP);
    chk("drop_valid", {31'b0, decode_valid}, 32'd0);
    chk("drop_new_addr", imem_addr, 32'h100);

    // Redirect and ack in the same cycle.
    doCycle(1'b1, 1'b1, 1'b1, 32'h40, 1'b1, memWord(32'h100));
    afterEdge();
    chk("flush_ack_ir", decodeIR_out, NOP);
    chk("flush_ack_valid", {31'b0, decode_valid}, 32'd0);
    chk("flush_ack_addr", imem_addr, 32'h40);

    // PC wrap at the top of the address space.
    doCycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, memWord(32'h40));
    doFetch(1'b1, 1'b1);
    afterEdge();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc", decode_pc, 32'hFFFF_FFFC);
    doFetch(1'b1, 1'b1);
    doFetch(1'b0, 1'b1);

    // Asynchronous reset while holding an instruction.
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    chk("async_imem_req", {31'b0, imem_req}, 32'd0);
    chk("async_imem_addr", imem_addr, 32'h0);
    chk("async_decodeIR", decodeIR_out, NOP);
    chk("async_decode_pc", decode_pc, 32'h0);
    chk("async_decode_valid", {31'b0, decode_valid}, 32'd0);
    modelReset();
    repeat (2) @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    driveStep(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic en, pcw, fl, ak;
      logic [31:0] tg, rd;
      en  = ($urandom_range(0, 3) != 0);
      pcw = ($urandom_range(0, 4) != 0);
      fl  = ($urandom_range(0, 11) == 0);
      tg  = $urandom;
      if ($urandom_range(0, 3) == 0) tg = 32'hFFFF_FFF0 | {28'h0, 2'b0, tg[1:0]};
      ak  = mReq ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) == 1);
      rd  = ak ? memWord(modelAddr()) : $urandom;
      doCycle(en, pcw, fl, tg, ak, rd);
    end

    @(negedge CLK);
    decodeIR_en = 1'b0; flush = 1'b0; imem_ack = 1'b0;
    afterEdge();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
